// File: rtl/dmem_port_arbiter.sv
// Shares the single dmem BRAM port between the core (C) and DMA (D) requesters.
// Core has fixed priority; a streak counter guarantees the DMA port a slot.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_wmask,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  streak_reg, streak_next;
  logic        rd_pend_reg, rd_owner_reg;
  logic        grant_c, grant_d;
  logic        read_xfer;
  logic [1:0]  rvalid_vec;
  logic [31:0] rdata_vec [2];

  always_comb begin
    grant_c = 1'b0;
    grant_d = 1'b0;
    if (c_valid && (!d_valid || streak_reg < LIMIT)) begin
      grant_c = 1'b1;
    end else if (d_valid) begin
      grant_d = 1'b1;
    end
  end

  assign c_ready = grant_c;
  assign d_ready = grant_d;

  always_comb begin
    mem_en   = grant_c | grant_d;
    mem_we   = 4'b0000;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_c) begin
      mem_we   = c_wmask;
      mem_addr = c_addr;
      mem_din  = c_wdata;
    end else if (grant_d) begin
      mem_we   = d_wmask;
      mem_addr = d_addr;
      mem_din  = d_wdata;
    end
  end

  assign read_xfer = (grant_c && (c_wmask == 4'b0000)) ||
                     (grant_d && (d_wmask == 4'b0000));

  // The streak only counts core wins that actually kept the DMA waiting.
  always_comb begin
    streak_next = streak_reg;
    if (!d_valid || grant_d) begin
      streak_next = 4'd0;
    end else if (grant_c && streak_reg != LIMIT) begin
      streak_next = streak_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg   <= 4'd0;
      rd_pend_reg  <= 1'b0;
      rd_owner_reg <= 1'b0;
    end else begin
      streak_reg  <= streak_next;
      rd_pend_reg <= read_xfer;
      if (read_xfer) begin
        rd_owner_reg <= grant_d;
      end
    end
  end

  // Port 0 is the core, port 1 the DMA; only the owner sees the BRAM data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rvalid_vec[gi] = rd_pend_reg && (rd_owner_reg == 1'(gi));
    assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_dout : 32'd0;
  end

  assign c_rvalid = rvalid_vec[0];
  assign d_rvalid = rvalid_vec[1];
  assign c_rdata  = rdata_vec[0];
  assign d_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of grants, memory and read returns.
module tb_dmem_port_arbiter;

  localparam int AW  = 14;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_valid, d_valid;
  logic          c_ready, d_ready;
  logic [AW-1:0] c_addr, d_addr;
  logic [31:0]   c_wdata, d_wdata;
  logic [3:0]    c_wmask, d_wmask;
  logic          c_rvalid, d_rvalid;
  logic [31:0]   c_rdata, d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_wmask(c_wmask), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // BRAM environment: byte-lane writes, registered read.
  logic [31:0] bram [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) bram[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end
      if (mem_we == 4'b0000) mem_dout <= bram[mem_addr[7:0]];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: how long the DMA has been kept waiting by the core,
  // a shadow memory, and the one expected read response for the next cycle.
  logic [31:0] ref_mem [0:255];
  int          m_wait  = 0;
  logic        m_pend  = 1'b0;
  logic        m_owner = 1'b0;
  logic [31:0] m_data  = 32'd0;

  always @(negedge clk) begin
    logic          egc, egd, rd;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [3:0]    ew;
    if (!rst_n) begin
      m_wait = 0;
      m_pend = 1'b0;
    end
    egc = c_valid && !(d_valid && m_wait >= LIM);
    egd = d_valid && !egc;
    ea  = egc ? c_addr  : (egd ? d_addr  : '0);
    ed  = egc ? c_wdata : (egd ? d_wdata : 32'd0);
    ew  = egc ? c_wmask : (egd ? d_wmask : 4'b0000);
    chk("c_ready",  32'(c_ready),  32'(egc));
    chk("d_ready",  32'(d_ready),  32'(egd));
    chk("mem_en",   32'(mem_en),   32'(egc || egd));
    chk("mem_we",   32'(mem_we),   32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_din",  mem_din, ed);
    chk("c_rvalid", 32'(c_rvalid), 32'(m_pend && !m_owner));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_pend && m_owner));
    chk("c_rdata",  c_rdata, (m_pend && !m_owner) ? m_data : 32'd0);
    chk("d_rdata",  d_rdata, (m_pend && m_owner) ? m_data : 32'd0);
    if (rst_n) begin
      rd     = (egc || egd) && (ew == 4'b0000);
      m_pend = rd;
      if (rd) begin
        m_owner = egd;
        m_data  = ref_mem[ea[7:0]];
      end
      for (int b = 0; b < 4; b++) begin
        if (ew[b]) ref_mem[ea[7:0]][8*b +: 8] = ed[8*b +: 8];
      end
      m_wait = (d_valid && egc) ? ((m_wait + 1 > LIM) ? LIM : m_wait + 1) : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic set_c(input logic v, input logic [AW-1:0] a, input logic [31:0] w, input logic [3:0] m);
    c_valid = v; c_addr = a; c_wdata = w; c_wmask = m;
  endtask

  task automatic set_d(input logic v, input logic [AW-1:0] a, input logic [31:0] w, input logic [3:0] m);
    d_valid = v; d_addr = a; d_wdata = w; d_wmask = m;
  endtask

  logic [AW-1:0] pre_addr [4];
  logic [31:0]   pre_data [4];
  logic [AW-1:0] addr_tab [5];
  logic [9:0]    d_pat;
  logic          c_acc, d_acc;

  initial begin
    pre_addr = '{14'h010, 14'h001, 14'h002, 14'h020};
    pre_data = '{32'hDEADBEEF, 32'h0000000A, 32'h0000000B, 32'hCAFEF00D};
    addr_tab = '{14'h001, 14'h002, 14'h010, 14'h020, 14'h030};
    rst_n = 1'b0;
    set_c(1'b0, '0, 32'd0, 4'b0000);
    set_d(1'b0, '0, 32'd0, 4'b0000);

    // Reset with both valids low
    step(); step(); peek();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    step(); rst_n = 1'b1; peek();
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);
    chk("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);

    // Boot-loader style preload through the DMA port
    for (int i = 0; i < 4; i++) begin
      step(); set_d(1'b1, pre_addr[i], pre_data[i], 4'b1111); peek();
      chk("preload_d_ready", 32'(d_ready), 32'd1);
    end
    step(); set_d(1'b0, '0, 32'd0, 4'b0000);

    // Core-only read of 0x010
    set_c(1'b1, 14'h010, 32'd0, 4'b0000); peek();
    chk("core_rd_ready", 32'(c_ready), 32'd1);
    step(); set_c(1'b0, '0, 32'd0, 4'b0000); peek();
    chk("core_rd_rvalid", 32'(c_rvalid), 32'd1);
    chk("core_rd_data", c_rdata, 32'hDEADBEEF);
    chk("core_rd_d_rvalid", 32'(d_rvalid), 32'd0);

    // DMA partial write, then core read-back
    step(); set_d(1'b1, 14'h020, 32'h12345678, 4'b0011); peek();
    chk("dma_wr_mem_we", 32'(mem_we), 32'h3);
    step(); set_d(1'b0, '0, 32'd0, 4'b0000); set_c(1'b1, 14'h020, 32'd0, 4'b0000); peek();
    chk("partial_wr_no_resp", 32'(d_rvalid), 32'd0);
    step(); set_c(1'b0, '0, 32'd0, 4'b0000); peek();
    chk("partial_rdback", c_rdata, 32'hCAFE5678);

    // Continuous contention: d_ready every 5th cycle
    step();
    set_c(1'b1, 14'h001, 32'd0, 4'b0000);
    set_d(1'b1, 14'h030, 32'h55AA55AA, 4'b1111);
    peek(); d_pat[0] = d_ready;
    for (int i = 1; i < 10; i++) begin
      step(); peek(); d_pat[i] = d_ready;
    end
    chk("starve_pattern", 32'(d_pat), 32'h210);
    step(); set_c(1'b0, '0, 32'd0, 4'b0000); set_d(1'b0, '0, 32'd0, 4'b0000);

    // Alternating reads C@1 then D@2
    step(); set_c(1'b1, 14'h001, 32'd0, 4'b0000); peek();
    step(); set_c(1'b0, '0, 32'd0, 4'b0000); set_d(1'b1, 14'h002, 32'd0, 4'b0000); peek();
    chk("alt_d_ready", 32'(d_ready), 32'd1);
    chk("alt_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("alt_c_rdata", c_rdata, 32'h0000000A);
    chk("alt_d_rvalid_early", 32'(d_rvalid), 32'd0);
    step(); set_d(1'b0, '0, 32'd0, 4'b0000); peek();
    chk("alt_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("alt_d_rdata", d_rdata, 32'h0000000B);
    chk("alt_c_rvalid_late", 32'(c_rvalid), 32'd0);

    // Mixed traffic obeying the hold-while-stalled rule
    c_acc = 1'b1; d_acc = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!c_valid || c_acc)
        set_c($urandom_range(0, 3) != 0, addr_tab[$urandom_range(0, 4)], $urandom,
              ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      if (!d_valid || d_acc)
        set_d($urandom_range(0, 3) != 0, addr_tab[$urandom_range(0, 4)], $urandom,
              ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      peek();
      c_acc = c_valid && c_ready;
      d_acc = d_valid && d_ready;
    end
    step(); set_c(1'b0, '0, 32'd0, 4'b0000); set_d(1'b0, '0, 32'd0, 4'b0000);
    step();

    // Reset asserted while a read is in flight
    set_c(1'b1, 14'h010, 32'd0, 4'b0000); peek();
    step(); set_c(1'b0, '0, 32'd0, 4'b0000); rst_n = 1'b0; peek();
    chk("rst_drop_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_drop_c_rdata", c_rdata, 32'd0);
    step(); step(); rst_n = 1'b1; peek();
    chk("rst_drop_after", 32'(c_rvalid), 32'd0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory BRAM port between two requesters: the core load/store path (port C) and the DMA/boot-loader engine (port D).
- Sits between the store byte-lane formatting logic and the dmem BRAM.
- Core has fixed priority. A starvation counter guarantees the DMA port a slot.
- Read data returns one cycle after issue and is routed back to the requester that issued the read.

Parameters:
- ADDR_W, 14, word-address width presented to the BRAM.
- STARVE_LIMIT, 4, consecutive contended core grants after which DMA wins the next contended cycle; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- c_valid  input  1  core request valid.
- c_ready  output  1  core request accepted this cycle (combinational grant).
- c_addr  input  ADDR_W  core word address.
- c_wdata  input  32  core write data, already lane-aligned.
- c_wmask  input  4  core byte write mask; 4'b0000 means read.
- c_rvalid  output  1  core read data valid.
- c_rdata  output  32  core read data.
- d_valid, d_ready, d_addr, d_wdata, d_wmask, d_rvalid, d_rdata: same as the c_* ports, for the DMA port.
- mem_en  output  1  BRAM enable.
- mem_we  output  4  BRAM byte write enables.
- mem_addr  output  ADDR_W  BRAM address.
- mem_din  output  32  BRAM write data.
- mem_dout  input  32  BRAM read data; valid the cycle after an enabled read.

Behaviour:
- Grant logic (combinational, from valids and the streak counter):
  - Only c_valid: grant C.
  - Only d_valid: grant D.
  - Both valid and streak < STARVE_LIMIT: grant C.
  - Both valid and streak == STARVE_LIMIT: grant D.
  - Neither valid: no grant.
- Handshake:
  - x_ready = x_valid & granted to x; at most one ready is high per cycle.
  - A request is transferred when valid & ready.
  - A requester must hold addr, wdata and wmask stable while valid & !ready.
- Memory drive (combinational):
  - With a grant: mem_en=1, mem_addr, mem_din and mem_we come from the granted port.
  - Without a grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Streak counter (4 bits):
  - Increments when C is granted while d_valid=1.
  - Clears to 0 when D is granted, or when d_valid=0.
  - Saturates at STARVE_LIMIT.
- Read return:
  - rd_pend (1 bit) and rd_owner (1 bit) are registered on every accepted transfer with wmask==0.
  - Next cycle: the owner's rvalid=1 and its rdata=mem_dout. The other port's rvalid=0 and its rdata=0.
  - Writes produce no response.
  - Back-to-back reads are fully pipelined, one per cycle, in any owner interleaving.
- A partial mask (for example 4'b0110) is a write. The arbiter never inspects lane alignment.
- Reset, effective immediately and asynchronously:
  - streak=0, rd_pend=0, rd_owner=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0.
  - A read in flight at reset is dropped and no rvalid follows.
  - Combinational outputs follow the inputs even while rst_n=0. Requesters must deassert valid during reset.
- Simultaneous events:
  - The grant and the response of a prior read may occur in the same cycle, on the same port or on different ports. Both proceed.
- Latency:
  - Request to ready: 0 cycles when uncontended.
  - Accepted read to rvalid: exactly 1 cycle.
  - Worst-case DMA wait under a continuous core stream: STARVE_LIMIT cycles.

Test Plan:
- Reset with both valids low, then release → all outputs 0, mem_en=0. Assert rst_n=0 one cycle after a read is accepted → no rvalid appears.
- Core-only read at addr 0x010, BRAM preloaded with 0xDEADBEEF → c_ready same cycle; next cycle c_rvalid=1 and c_rdata=0xDEADBEEF; d_rvalid stays 0.
- DMA write addr 0x020, wdata 0x12345678, wmask 4'b0011 → mem_we=4'b0011 for one cycle. A subsequent core read of 0x020 returns 0xXXXX5678, with the upper bytes unchanged.
- c_valid and d_valid held high continuously, STARVE_LIMIT=4 → grant pattern C,C,C,C,D,C,C,C,C,D…; d_ready pulses every 5th cycle.
- Alternating reads, C@0x1 then D@0x2 on consecutive cycles, memory holding 0xA and 0xB → c_rvalid with 0xA, then d_rvalid with 0xB on the next cycle; never both rvalid in the same cycle.
- DMA valid with wmask=0 arrives in the cycle a core read returns → d_ready=1 and c_rvalid=1 in the same cycle; d_rvalid follows one cycle later.
